// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, datapath width
// and helpers that classify an op as mult-class, div-class or signed.
package md_pkg;

  localparam int MD_W = 32;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MADD  = 4'd7,
    MD_MADDU = 4'd8,
    MD_MSUB  = 4'd9,
    MD_MSUBU = 4'd10
  } md_op_e;

  function automatic logic md_is_mult(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  // Accumulating multiplies; only honoured when the accumulate feature is built.
  function automatic logic md_is_mac(input logic [3:0] op);
    return (op == MD_MADD) || (op == MD_MADDU) || (op == MD_MSUB) || (op == MD_MSUBU);
  endfunction

  function automatic logic md_is_div(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_signed(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_DIV) || (op == MD_MADD) || (op == MD_MSUB);
  endfunction

endpackage

// File: rtl/md_core.sv
// Combinational MD datapath: 64-bit {hi,lo} result and divide-by-zero flag, zero latency,
// no flow control. The accumulate adder and its acc port exist only under MD_MADD_EN.
module md_core
  import md_pkg::*;
(
  input  logic [3:0]        op,
  input  logic [MD_W-1:0]   a,
  input  logic [MD_W-1:0]   b,
`ifdef MD_MADD_EN
  input  logic [2*MD_W-1:0] acc,
`endif
  output logic [2*MD_W-1:0] res,
  output logic              no_write
);

  logic              sx;
  logic [2*MD_W-1:0] a_ext;
  logic [2*MD_W-1:0] b_ext;
  logic [2*MD_W-1:0] prod;
  logic [MD_W-1:0]   a_mag;
  logic [MD_W-1:0]   b_mag;
  logic [MD_W-1:0]   dvs;
  logic [MD_W-1:0]   q_mag;
  logic [MD_W-1:0]   r_mag;
  logic [MD_W-1:0]   quo;
  logic [MD_W-1:0]   rem;

  assign sx = md_is_signed(op);

  // Low 64 bits of the product of sign/zero-extended operands serve both signednesses.
  assign a_ext = {{MD_W{sx & a[MD_W-1]}}, a};
  assign b_ext = {{MD_W{sx & b[MD_W-1]}}, b};
  assign prod  = a_ext * b_ext;

  // One unsigned divider on magnitudes; signs restored afterwards (truncating division).
  assign a_mag = (sx && a[MD_W-1]) ? -a : a;
  assign b_mag = (sx && b[MD_W-1]) ? -b : b;
  assign dvs   = (b_mag == '0) ? {{(MD_W-1){1'b0}}, 1'b1} : b_mag;
  assign q_mag = a_mag / dvs;
  assign r_mag = a_mag % dvs;
  assign quo   = (sx && (a[MD_W-1] ^ b[MD_W-1])) ? -q_mag : q_mag;
  assign rem   = (sx && a[MD_W-1]) ? -r_mag : r_mag;

  always_comb begin
    res      = '0;
    no_write = 1'b0;
    if (md_is_div(op)) begin
      res      = {rem, quo};
      no_write = (b == '0);
    end else if (md_is_mult(op)) begin
      res = prod;
    end
`ifdef MD_MADD_EN
    else if ((op == MD_MADD) || (op == MD_MADDU)) begin
      res = acc + prod;
    end else if ((op == MD_MSUB) || (op == MD_MSUBU)) begin
      res = acc - prod;
    end
`endif
  end

endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide unit holding HI/LO: MULT-class busy MULT_CYCLES, DIV-class DIV_CYCLES,
// MTHI/MTLO single-cycle; never stalls, starts during busy are dropped. MD_MADD_EN adds MADD/MSUB.
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [3:0]      op,
  input  logic [MD_W-1:0] a,
  input  logic [MD_W-1:0] b,
  output logic            busy,
  output logic [MD_W-1:0] hi,
  output logic [MD_W-1:0] lo
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*MD_W-1:0] pend_q, pend_d;
  logic              pend_nw_q, pend_nw_d;
  logic [MD_W-1:0]   hi_q, hi_d;
  logic [MD_W-1:0]   lo_q, lo_d;

  logic              is_mul;
  logic              is_div;
  logic [2*MD_W-1:0] core_res;
  logic              core_nw;

`ifdef MD_MADD_EN
  assign is_mul = md_is_mult(op) | md_is_mac(op);
`else
  assign is_mul = md_is_mult(op);
`endif
  assign is_div = md_is_div(op);

  md_core u_core (
    .op       (op),
    .a        (a),
    .b        (b),
`ifdef MD_MADD_EN
    .acc      ({hi_q, lo_q}),
`endif
    .res      (core_res),
    .no_write (core_nw)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    pend_nw_d = pend_nw_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (is_mul || is_div) begin
            pend_d    = core_res;
            pend_nw_d = core_nw;
            cnt_d     = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            state_d   = ST_RUN;
          end else if (op == MD_MTHI) begin
            hi_d = a;
          end else if (op == MD_MTLO) begin
            lo_d = a;
          end
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        // The edge that takes the counter to zero is the commit edge.
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          if (!pend_nw_q) begin
            hi_d = pend_q[2*MD_W-1:MD_W];
            lo_d = pend_q[MD_W-1:0];
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pend_q    <= '0;
      pend_nw_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      pend_nw_q <= pend_nw_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed scenarios plus randomized ops against a
// plain-arithmetic model of HI/LO and busy duration.
module tb_md_unit;
  import md_pkg::*;

  localparam int MULT_CYC = 5;
  localparam int DIV_CYC  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] m_acc;

  md_unit #(
    .MULT_CYCLES (MULT_CYC),
    .DIV_CYCLES  (DIV_CYC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Expected {hi,lo} after an op, from the architectural arithmetic rules.
  function automatic logic [63:0] model_res(input logic [3:0] o, input logic [31:0] x,
                                            input logic [31:0] y, input logic [63:0] acc);
    longint      sx, sy, q, r;
    logic [63:0] ux, uy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    model_res = acc;
    case (o)
      4'd1: model_res = sx * sy;
      4'd2: model_res = ux * uy;
      4'd3: if (y != 0) begin
              q = sx / sy;
              r = sx % sy;
              model_res = {r[31:0], q[31:0]};
            end
      4'd4: if (y != 0) model_res = {x % y, x / y};
      4'd5: model_res = {x, acc[31:0]};
      4'd6: model_res = {acc[63:32], x};
`ifdef MD_MADD_EN
      4'd7:  model_res = acc + sx * sy;
      4'd8:  model_res = acc + ux * uy;
      4'd9:  model_res = acc - sx * sy;
      4'd10: model_res = acc - ux * uy;
`endif
      default: ;
    endcase
  endfunction

  function automatic int model_n(input logic [3:0] o);
    if (o == 4'd1 || o == 4'd2) return MULT_CYC;
    if (o == 4'd3 || o == 4'd4) return DIV_CYC;
`ifdef MD_MADD_EN
    if (o >= 4'd7 && o <= 4'd10) return MULT_CYC;
`endif
    return 0;
  endfunction

  function automatic logic [31:0] pick_val();
    logic [31:0] sp [5];
    sp[0] = 32'h0000_0000;
    sp[1] = 32'h0000_0001;
    sp[2] = 32'hFFFF_FFFF;
    sp[3] = 32'h8000_0000;
    sp[4] = 32'h7FFF_FFFF;
    if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  // Called away from the rising edge; issues one op and counts busy cycles.
  // Returns at the falling edge of the first non-busy cycle after the start edge.
  task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                        input bit spur, output int bcnt);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    if (spur) begin
      start = 1'b1;
      op    = 4'($urandom_range(1, 15));
    end else begin
      start = 1'b0;
      op    = 4'd0;
    end
    a    = $urandom;
    b    = $urandom;
    bcnt = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (busy !== 1'b1) break;
      bcnt++;
    end
    start = 1'b0;
    op    = 4'd0;
  endtask

  task automatic do_reset();
    start = 1'b0;
    op    = 4'd0;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    m_acc = '0;
  endtask

  task automatic test_reset();
    start = 1'b0;
    op    = 4'd0;
    a     = '0;
    b     = '0;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    #2;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi: got %h want 00000000", hi); end
    n_checks++; if (lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo: got %h want 00000000", lo); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mult();
    int bc;
    run_op(MD_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0, bc);
    n_checks++; if (bc != 5) begin n_fail++; $display("FAIL mult_busy: got %0d cycles want 5", bc); end
    n_checks++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
    n_checks++; if (lo !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mult_lo: got %h want ffffffeb", lo); end
    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, bc);
    n_checks++; if (bc != 5) begin n_fail++; $display("FAIL multu_busy: got %0d cycles want 5", bc); end
    n_checks++; if (hi !== 32'h0000_0001) begin n_fail++; $display("FAIL multu_hi: got %h want 00000001", hi); end
    n_checks++; if (lo !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL multu_lo: got %h want fffffffe", lo); end
  endtask

  task automatic test_div();
    int bc;
    run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, bc);
    n_checks++; if (bc != 10) begin n_fail++; $display("FAIL div_busy: got %0d cycles want 10", bc); end
    n_checks++; if (lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_lo: got %h want fffffffd", lo); end
    n_checks++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_hi: got %h want ffffffff", hi); end
    run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, bc);
    n_checks++; if (lo !== 32'h8000_0000) begin n_fail++; $display("FAIL div_ovf_lo: got %h want 80000000", lo); end
    n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL div_ovf_hi: got %h want 00000000", hi); end
  endtask

  task automatic test_mthi_div0();
    int bc;
    run_op(MD_MTHI, 32'h1234_5678, 32'h0, 1'b0, bc);
    n_checks++; if (hi !== 32'h1234_5678) begin n_fail++; $display("FAIL mthi_hi: got %h want 12345678", hi); end
    n_checks++; if (bc != 0) begin n_fail++; $display("FAIL mthi_busy: got %0d cycles want 0", bc); end
    run_op(MD_MTLO, 32'h5A5A_5A5A, 32'h0, 1'b0, bc);
    n_checks++; if (lo !== 32'h5A5A_5A5A) begin n_fail++; $display("FAIL mtlo_lo: got %h want 5a5a5a5a", lo); end
    run_op(MD_DIVU, 32'hDEAD_BEEF, 32'h0, 1'b0, bc);
    n_checks++; if (bc != 10) begin n_fail++; $display("FAIL div0_busy: got %0d cycles want 10", bc); end
    n_checks++; if (hi !== 32'h1234_5678) begin n_fail++; $display("FAIL div0_hi: got %h want 12345678", hi); end
    n_checks++; if (lo !== 32'h5A5A_5A5A) begin n_fail++; $display("FAIL div0_lo: got %h want 5a5a5a5a", lo); end
  endtask

  task automatic test_ignore_and_reset();
    int bc;
    run_op(MD_MTHI, 32'h1111_1111, 32'h0, 1'b0, bc);
    run_op(MD_MTLO, 32'h2222_2222, 32'h0, 1'b0, bc);
    start = 1'b1; op = MD_MULT; a = 32'd3; b = 32'd5;
    @(posedge clk); #1;
    start = 1'b0; op = 4'd0;
    @(posedge clk); #1;
    start = 1'b1; op = MD_MTLO; a = 32'h0000_AAAA;
    @(posedge clk); #1;
    start = 1'b0; op = 4'd0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ign_busy: got %b want 1", busy); end
    n_checks++; if (lo !== 32'h2222_2222) begin n_fail++; $display("FAIL ign_lo: got %h want 22222222", lo); end
    reset = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", busy); end
    n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL midrst_hi: got %h want 00000000", hi); end
    n_checks++; if (lo !== 32'h0) begin n_fail++; $display("FAIL midrst_lo: got %h want 00000000", lo); end
    @(negedge clk);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL postrst_busy: got %b want 0", busy); end
    n_checks++; if ({hi, lo} !== 64'h0) begin n_fail++; $display("FAIL postrst_hilo: got %h want 0", {hi, lo}); end
  endtask

  task automatic test_madd();
    int bc;
    run_op(MD_MTHI, 32'h0, 32'h0, 1'b0, bc);
    run_op(MD_MTLO, 32'hFFFF_FFFF, 32'h0, 1'b0, bc);
    run_op(MD_MADDU, 32'd1, 32'd1, 1'b0, bc);
`ifdef MD_MADD_EN
    n_checks++; if (bc != 5) begin n_fail++; $display("FAIL maddu_busy: got %0d cycles want 5", bc); end
    n_checks++; if (hi !== 32'h1) begin n_fail++; $display("FAIL maddu_hi: got %h want 00000001", hi); end
    n_checks++; if (lo !== 32'h0) begin n_fail++; $display("FAIL maddu_lo: got %h want 00000000", lo); end
`else
    n_checks++; if (bc != 0) begin n_fail++; $display("FAIL maddu_busy: got %0d cycles want 0", bc); end
    n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL maddu_hi: got %h want 00000000", hi); end
    n_checks++; if (lo !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL maddu_lo: got %h want ffffffff", lo); end
`endif
  endtask

  // Each op starts at the first cycle busy is low, so ops run back to back.
  task automatic test_back_to_back_random();
    int          bc, n;
    logic [3:0]  o;
    logic [31:0] x, y;
    bit          spur;
    do_reset();
    for (int it = 0; it < 120; it++) begin
      o     = 4'($urandom_range(0, 15));
      x     = pick_val();
      y     = pick_val();
      n     = model_n(o);
      spur  = (n > 0) && ($urandom_range(0, 1) == 1);
      m_acc = model_res(o, x, y, m_acc);
      run_op(o, x, y, spur, bc);
      n_checks++; if (bc != n) begin n_fail++; $display("FAIL rnd_busy it=%0d op=%0d: got %0d want %0d", it, o, bc, n); end
      n_checks++; if (hi !== m_acc[63:32]) begin n_fail++; $display("FAIL rnd_hi it=%0d op=%0d a=%h b=%h: got %h want %h", it, o, x, y, hi, m_acc[63:32]); end
      n_checks++; if (lo !== m_acc[31:0]) begin n_fail++; $display("FAIL rnd_lo it=%0d op=%0d a=%h b=%h: got %h want %h", it, o, x, y, lo, m_acc[31:0]); end
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_mthi_div0();
    test_ignore_and_reset();
    test_madd();
    test_back_to_back_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
